// File: rtl/seq_adder_pkg.sv
// Package for the chunked sequential adder.
// Holds the FSM state encoding and the helpers that derive the chunk count
// and the chunk-index width from WIDTH/CHUNK.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of chunks processed per operation.
  function automatic int nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index register; at least one bit so a
  // single-chunk configuration still has a legal vector.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_add_chunk.sv
// add_chunk: combinational CHUNK-bit adder slice, {co,s} = a + b + ci.
// Ports:
//   a, b  CHUNK-bit addends
//   ci    carry in
//   s     CHUNK-bit sum
//   co    carry out
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle adder/subtractor that processes CHUNK bits
// per clock, low chunk first, with the carry held in a register between
// chunks. Valid/ready handshakes on the operand and result sides.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/mode valid          in_ready   block can accept
//   a, b       WIDTH-bit unsigned operands  sub        0: a+b, 1: a-b
//   out_valid  result valid                 out_ready  consumer accepts
//   out        WIDTH-bit result
//   carry      add: carry-out; sub: NOT borrow (1 means a >= b)
// Configuration macro: SEQ_CHUNK_ADDER_SAT_EN
//   defined   -> result saturates (all ones on add overflow, zero on borrow);
//                carry still reports the raw carry/borrow.
//   undefined -> result wraps modulo 2^WIDTH.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  localparam int NCH = nch(WIDTH, CHUNK);
  localparam int IW  = idx_width(NCH);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK and CHUNK <= WIDTH");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             sub_reg;
  logic             carry_reg;      // running inter-chunk carry
  logic             carry_out_reg;  // carry reported with the result
  logic [IW-1:0]    idx_reg;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic             last;

  assign last = (idx_reg == IW'(NCH - 1));

  // Operands are shifted right each BUSY cycle, so the current chunk is
  // always the low CHUNK bits; one adder instance serves every chunk.
  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a  (a_reg[CHUNK-1:0]),
    .b  (b_reg[CHUNK-1:0]),
    .ci (carry_reg),
    .s  (chunk_s),
    .co (chunk_c)
  );

  // Result update: only the slice selected by idx_reg takes the new sum,
  // so out holds the partial result in place while BUSY.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      assign out_next[gi*CHUNK +: CHUNK] =
        (idx_reg == IW'(gi)) ? chunk_s : out_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg         <= '0;
      b_reg         <= '0;
      out_reg       <= '0;
      sub_reg       <= 1'b0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      idx_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b here, seed carry with 1.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            sub_reg   <= sub;
            carry_reg <= sub;
            idx_reg   <= '0;
          end
        end
        BUSY: begin
          a_reg     <= a_reg >> CHUNK;
          b_reg     <= b_reg >> CHUNK;
          carry_reg <= chunk_c;
          idx_reg   <= idx_reg + IW'(1);
          out_reg   <= out_next;
          if (last) begin
            carry_out_reg <= chunk_c;
`ifdef SEQ_CHUNK_ADDER_SAT_EN
            if (!sub_reg && chunk_c) begin
              out_reg <= '1;
            end else if (sub_reg && !chunk_c) begin
              out_reg <= '0;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign out   = out_reg;
  assign carry = carry_out_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: three instances (16/4, 32/8, 8/8) share a
// clock and reset. Directed vectors with hand-computed results on the
// 16/4 instance, plus boundary and random vectors on the other two
// against a full-width reference model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  in_valid = '0;
  logic [2:0]  out_ready = '0;
  logic [2:0]  in_ready, out_valid, carry;
  logic [15:0] a0 = '0, b0 = '0;
  logic [31:0] a1 = '0, b1 = '0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic [2:0]  sub_v = '0;
  logic [15:0] out0;
  logic [31:0] out1;
  logic [7:0]  out2;

  int checks = 0;
  int passes = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a0), .b(b0), .sub(sub_v[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out(out0), .carry(carry[0]));

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a1), .b(b1), .sub(sub_v[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out(out1), .carry(carry[1]));

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a2), .b(b2), .sub(sub_v[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out(out2), .carry(carry[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  function automatic logic [31:0] get_out(input int which);
    case (which)
      0:       return {16'd0, out0};
      1:       return out1;
      default: return {24'd0, out2};
    endcase
  endfunction

  // Full-width reference: returns {carry, result}.
  function automatic logic [32:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic sv, input int w);
    longint unsigned mask, full, res;
    logic c;
    mask = (64'd1 << w) - 64'd1;
    full = (longint'(av) & mask) + (sv ? (~longint'(bv) & mask) : (longint'(bv) & mask))
           + (sv ? 64'd1 : 64'd0);
    res  = full & mask;
    c    = full[w];
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    if (!sv && c) res = mask;
    if (sv && !c) res = 64'd0;
`endif
    return {c, res[31:0]};
  endfunction

  task automatic drive(input int which, input logic [31:0] av, input logic [31:0] bv, input logic sv);
    case (which)
      0:       begin a0 = av[15:0]; b0 = bv[15:0]; end
      1:       begin a1 = av;       b1 = bv;       end
      default: begin a2 = av[7:0];  b2 = bv[7:0];  end
    endcase
    sub_v[which] = sv;
  endtask

  // One full transaction; lat counts clocks from accept edge to out_valid.
  task automatic do_op(input int which, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, output logic [31:0] res, output logic c, output int lat);
    int wait_cnt = 0;
    while (!in_ready[which] && wait_cnt < 50) begin
      @(posedge clk); #1; wait_cnt++;
    end
    drive(which, av, bv, sv);
    in_valid[which] = 1'b1;
    @(posedge clk); #1;
    in_valid[which] = 1'b0;
    lat = 0;
    while (!out_valid[which] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = get_out(which);
    c   = carry[which];
    out_ready[which] = 1'b1;
    @(posedge clk); #1;
    out_ready[which] = 1'b0;
    $display("op dut%0d a=%0h b=%0h sub=%0b -> out=%0h carry=%0b lat=%0d",
             which, av, bv, sv, res, c, lat);
  endtask

  logic [31:0] res, res_hold;
  logic        c, c_hold;
  int          lat;
  logic [32:0] exp;
  int          saw_valid;

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out0, 16'd0);
    check("rst_carry", carry[0], 1'b0);
    check("rst_out_valid", out_valid, 3'b000);
    check("rst_in_ready", in_ready, 3'b111);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 3'b111);

    // 1. Overflow.
    do_op(0, 32'd65535, 32'd1, 1'b0, res, c, lat);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    check("ovf_out", res, 32'd65535);
`else
    check("ovf_out", res, 32'd0);
`endif
    check("ovf_carry", c, 1'b1);
    check("ovf_lat", lat, 4);
    #0;
    check("drain_out_valid", out_valid[0], 1'b0);
    check("drain_in_ready", in_ready[0], 1'b1);

    // 2. Plain add.
    do_op(0, 32'd5, 32'd23, 1'b0, res, c, lat);
    check("add_out", res, 32'd28);
    check("add_carry", c, 1'b0);

    // 3. Subtract, both borrow and no-borrow.
    do_op(0, 32'd5, 32'd23, 1'b1, res, c, lat);
`ifdef SEQ_CHUNK_ADDER_SAT_EN
    check("sub_borrow_out", res, 32'd0);
`else
    check("sub_borrow_out", res, 32'd65518);
`endif
    check("sub_borrow_carry", c, 1'b0);
    do_op(0, 32'd23, 32'd5, 1'b1, res, c, lat);
    check("sub_out", res, 32'd18);
    check("sub_carry", c, 1'b1);
    check("sub_lat", lat, 4);

    // 4. Backpressure: hold result for 10 clocks, inject an ignored in_valid.
    drive(0, 32'd100, 32'd200, 1'b0);
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("bp_lat", lat, 4);
    check("bp_out", out0, 16'd300);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        drive(0, 32'd1, 32'd1, 1'b1);
        in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(posedge clk); #1;
      check("bp_stable_out", out0, 16'd300);
      check("bp_stable_carry", carry[0], 1'b0);
      check("bp_in_ready", in_ready[0], 1'b0);
      check("bp_out_valid", out_valid[0], 1'b1);
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_after_drain_valid", out_valid[0], 1'b0);
    check("bp_after_drain_ready", in_ready[0], 1'b1);
    $display("backpressure hold done out=%0d", out0);

    // 5. Reset two clocks into BUSY.
    drive(0, 32'd1234, 32'd1111, 1'b0);
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out", out0, 16'd0);
    check("midrst_out_valid", out_valid[0], 1'b0);
    check("midrst_in_ready", in_ready[0], 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) saw_valid++;
    end
    check("midrst_no_pulse", saw_valid, 0);
    do_op(0, 32'd7, 32'd8, 1'b0, res, c, lat);
    check("post_rst_out", res, 32'd15);
    check("post_rst_carry", c, 1'b0);
    check("post_rst_lat", lat, 4);

    // 6a. 32/8 boundary cases then random sweep.
    do_op(1, 32'hFFFF_FFFF, 32'd1, 1'b0, res, c, lat);
    exp = model(32'hFFFF_FFFF, 32'd1, 1'b0, 32);
    check("w32_ovf_out", res, exp[31:0]);
    check("w32_ovf_carry", c, 1'b1);
    check("w32_ovf_lat", lat, 4);
    do_op(1, 32'd0, 32'd1, 1'b1, res, c, lat);
    exp = model(32'd0, 32'd1, 1'b1, 32);
    check("w32_borrow_out", res, exp[31:0]);
    check("w32_borrow_carry", c, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      do_op(1, ra, rb, rs, res, c, lat);
      exp = model(ra, rb, rs, 32);
      check("w32_rand_out", res, exp[31:0]);
      check("w32_rand_carry", c, exp[32]);
      check("w32_rand_lat", lat, 4);
    end

    // 6b. 8/8: a single BUSY cycle.
    do_op(2, 32'd255, 32'd1, 1'b0, res, c, lat);
    exp = model(32'd255, 32'd1, 1'b0, 8);
    check("w8_ovf_out", res, exp[31:0]);
    check("w8_ovf_carry", c, 1'b1);
    check("w8_ovf_lat", lat, 1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      do_op(2, ra, rb, rs, res, c, lat);
      exp = model(ra, rb, rs, 8);
      check("w8_rand_out", res, exp[31:0]);
      check("w8_rand_carry", c, exp[32]);
      check("w8_rand_lat", lat, 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
